// File: rtl/dekatron_count_sequencer_if.sv
// Command channel of the dekatron count sequencer.
// Handshake: a command transfers on a Clk edge where Cmd_Valid and Cmd_Ready are both high.
// The master holds all Cmd_* fields stable while Cmd_Valid is high.
interface dekatron_count_sequencer_if #(
    parameter int WIDTH       = 4,
    parameter int COUNT_WIDTH = 8
);
    logic                   Cmd_Valid;
    logic                   Cmd_Ready;
    logic [1:0]             Cmd_Op;
    logic [COUNT_WIDTH-1:0] Cmd_Count;
    logic [WIDTH-1:0]       Cmd_Data;
    logic                   Cmd_StopOnZero;

    modport master (
        output Cmd_Valid, Cmd_Op, Cmd_Count, Cmd_Data, Cmd_StopOnZero,
        input  Cmd_Ready
    );

    modport slave (
        input  Cmd_Valid, Cmd_Op, Cmd_Count, Cmd_Data, Cmd_StopOnZero,
        output Cmd_Ready
    );
endinterface

// File: rtl/dekatron_count_sequencer.sv
// Command-level sequencer for one DekatronCounter: runs INC/DEC-by-N, SET and CLEAR
// one counter step at a time, with early stop on zero, abort and a per-step watchdog.
module dekatron_count_sequencer #(
    parameter int WIDTH       = 4,
    parameter int COUNT_WIDTH = 8,
    parameter int SET_HOLD    = 2,
    parameter int GUARD       = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    dekatron_count_sequencer_if.slave cmd,
    input  logic                   Abort,
    output logic                   Cnt_Request,
    output logic                   Cnt_Dec,
    output logic                   Cnt_Set,
    output logic [WIDTH-1:0]       Cnt_In,
    input  logic                   Cnt_Ready,
    input  logic                   Cnt_Zero,
    output logic                   Done,
    output logic                   ZeroStop,
    output logic                   TimedOut,
    output logic [COUNT_WIDTH-1:0] Remaining,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_LOAD   = 3'd2,
        S_GUARD  = 3'd3,
        S_WAIT   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;

    localparam int HOLD_W  = (SET_HOLD < 2) ? 1 : $clog2(SET_HOLD);
    localparam int GUARD_W = (GUARD < 2)    ? 1 : $clog2(GUARD);
    localparam int WD_W    = (TIMEOUT < 2)  ? 1 : $clog2(TIMEOUT);

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(SET_HOLD - 1);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD - 1);
    localparam logic [WD_W-1:0]    WD_LAST    = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t                 state, next_state;
    logic                   is_load_q;
    logic                   soz_q;
    logic                   abort_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [GUARD_W-1:0]     guard_cnt;
    logic [WD_W-1:0]        wd_cnt;

    logic accept;
    logic abort_window;
    logic zero_hit;
    logic wd_hit;

    assign accept       = (state == S_IDLE) && cmd.Cmd_Valid;
    assign abort_window = (state == S_ISSUE) || (state == S_LOAD) ||
                          (state == S_GUARD) || (state == S_WAIT);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        zero_hit   = 1'b0;
        wd_hit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd.Cmd_Op[1])              next_state = S_LOAD;
                    else if (cmd.Cmd_Count != '0)   next_state = S_ISSUE;
                    else                            next_state = S_FINISH;
                end
            end
            S_ISSUE: next_state = S_GUARD;
            S_LOAD:  if (hold_cnt == HOLD_LAST)   next_state = S_GUARD;
            S_GUARD: if (guard_cnt == GUARD_LAST) next_state = S_WAIT;
            S_WAIT: begin
                if (Cnt_Ready) begin
                    // Priority after a completed step: abort, then zero stop, then continue.
                    if (is_load_q || Abort || abort_q) begin
                        next_state = S_FINISH;
                    end else if (soz_q && Cnt_Zero && (count_q != '0)) begin
                        zero_hit   = 1'b1;
                        next_state = S_FINISH;
                    end else if (count_q != '0) begin
                        next_state = S_ISSUE;
                    end else begin
                        next_state = S_FINISH;
                    end
                end else if ((TIMEOUT != 0) && (wd_cnt == WD_LAST)) begin
                    wd_hit     = 1'b1;
                    next_state = S_FINISH;
                end
            end
            S_FINISH: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            is_load_q <= 1'b0;
            soz_q     <= 1'b0;
            abort_q   <= 1'b0;
            count_q   <= '0;
            hold_cnt  <= '0;
            guard_cnt <= '0;
            wd_cnt    <= '0;
            Cnt_Dec   <= 1'b0;
            Cnt_In    <= '0;
            ZeroStop  <= 1'b0;
            TimedOut  <= 1'b0;
        end else begin
            hold_cnt  <= (state == S_LOAD)  ? hold_cnt + 1'b1  : '0;
            guard_cnt <= (state == S_GUARD) ? guard_cnt + 1'b1 : '0;
            wd_cnt    <= (state == S_WAIT)  ? wd_cnt + 1'b1    : '0;

            if (accept) begin
                is_load_q <= cmd.Cmd_Op[1];
                soz_q     <= cmd.Cmd_StopOnZero;
                abort_q   <= 1'b0;
                count_q   <= cmd.Cmd_Op[1] ? '0 : cmd.Cmd_Count;
                Cnt_Dec   <= (cmd.Cmd_Op == OP_DEC);
                Cnt_In    <= (cmd.Cmd_Op == OP_SET) ? cmd.Cmd_Data : '0;
                ZeroStop  <= 1'b0;
                TimedOut  <= 1'b0;
            end

            if (abort_window && Abort) abort_q <= 1'b1;
            if (state == S_ISSUE)      count_q <= count_q - 1'b1;
            if (state == S_FINISH)     Cnt_Dec <= 1'b0;
            if (zero_hit)              ZeroStop <= 1'b1;
            if (wd_hit)                TimedOut <= 1'b1;
        end
    end

    assign cmd.Cmd_Ready = (state == S_IDLE);
    assign Cnt_Request   = (state == S_ISSUE);
    assign Cnt_Set       = (state == S_LOAD);
    assign Done          = (state == S_FINISH);
    assign Remaining     = count_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_dekatron_count_sequencer.sv
// Directed bench for dekatron_count_sequencer against a behavioural decimal dekatron counter.
module tb_dekatron_count_sequencer;

    localparam int WIDTH = 4;
    localparam int CW    = 8;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GUARD = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             abort = 1'b0;
    logic             cnt_request, cnt_dec, cnt_set;
    logic [WIDTH-1:0] cnt_in;
    logic             cnt_ready, cnt_zero;
    logic             done, zero_stop, timed_out;
    logic [CW-1:0]    remaining;
    logic [2:0]       dbg_state;

    dekatron_count_sequencer_if #(.WIDTH(WIDTH), .COUNT_WIDTH(CW)) cmd_bus ();

    dekatron_count_sequencer #(
        .WIDTH(WIDTH), .COUNT_WIDTH(CW), .SET_HOLD(2), .GUARD(1), .TIMEOUT(10)
    ) dut (
        .Clk(clk), .Rst_n(rst_n), .cmd(cmd_bus), .Abort(abort),
        .Cnt_Request(cnt_request), .Cnt_Dec(cnt_dec), .Cnt_Set(cnt_set), .Cnt_In(cnt_in),
        .Cnt_Ready(cnt_ready), .Cnt_Zero(cnt_zero),
        .Done(done), .ZeroStop(zero_stop), .TimedOut(timed_out), .Remaining(remaining),
        .dbg_state(dbg_state)
    );

    // ---------------- counter model (decimal, busy 4 cycles per step) ----------------
    logic       stall        = 1'b0;
    int         busy         = 0;
    logic       step_pending = 1'b0;
    logic       step_dec     = 1'b0;
    logic [3:0] value        = 4'd0;

    always @(posedge clk) begin
        if (cnt_request === 1'b1) begin
            busy         <= 4;
            step_pending <= 1'b1;
            step_dec     <= cnt_dec;
        end else if (cnt_set === 1'b1) begin
            value        <= cnt_in;
            busy         <= 2;
            step_pending <= 1'b0;
        end else if (busy != 0) begin
            busy <= busy - 1;
            if (busy == 1 && step_pending) begin
                step_pending <= 1'b0;
                if (step_dec) value <= (value == 4'd0) ? 4'd9 : value - 4'd1;
                else          value <= (value == 4'd9) ? 4'd0 : value + 4'd1;
            end
        end
    end

    assign cnt_ready = (busy == 0) && !stall;
    assign cnt_zero  = (value == 4'd0);

    // ---------------- monitor ----------------
    int         req_total = 0, dec_req_total = 0, set_total = 0, done_total = 0;
    int         overlap_total = 0, wait_total = 0;
    int         gap = 1000, min_gap = 1000;
    logic [3:0] set_in_last = 4'd0;

    always @(negedge clk) begin
        if (cnt_request === 1'b1) begin
            req_total++;
            if (cnt_dec) dec_req_total++;
            if (gap < min_gap) min_gap = gap;
            gap = 1;
        end else if (gap < 1000) begin
            gap++;
        end
        if (cnt_set === 1'b1) begin
            set_total++;
            set_in_last = cnt_in;
        end
        if (cnt_set === 1'b1 && cnt_request === 1'b1) overlap_total++;
        if (done === 1'b1) done_total++;
        if (dbg_state == ST_WAIT) wait_total++;
    end

    // ---------------- scoreboard ----------------
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] rem_seen;
    logic          zs_seen, to_seen;
    int            done_lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [CW-1:0] count,
                            input logic [WIDTH-1:0] data, input logic soz);
        int n;
        @(negedge clk);
        cmd_bus.Cmd_Op         = op;
        cmd_bus.Cmd_Count      = count;
        cmd_bus.Cmd_Data       = data;
        cmd_bus.Cmd_StopOnZero = soz;
        cmd_bus.Cmd_Valid      = 1'b1;
        n = 0;
        while (cmd_bus.Cmd_Ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(n), 0);
        @(posedge clk);
        #1 cmd_bus.Cmd_Valid = 1'b0;
    endtask

    task automatic finish_cmd(input string tag);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen     = 1'b1;
                rem_seen = remaining;
                zs_seen  = zero_stop;
                to_seen  = timed_out;
            end else begin
                n++;
            end
        end
        done_lat = n;
        check({tag, "_done_seen"}, 32'(seen), 1);
        check({tag, "_remaining"}, 32'(rem_seen), 32'(exp_q.pop_front()));
        repeat (2) @(negedge clk);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [CW-1:0] count,
                           input logic [WIDTH-1:0] data, input logic soz, input logic [CW-1:0] exp_rem);
        exp_q.push_back(exp_rem);
        send_cmd(op, count, data, soz);
        finish_cmd(tag);
    endtask

    int r0, d0, s0, k0, w0, n;

    initial begin
        cmd_bus.Cmd_Valid      = 1'b0;
        cmd_bus.Cmd_Op         = OP_INC;
        cmd_bus.Cmd_Count      = '0;
        cmd_bus.Cmd_Data       = '0;
        cmd_bus.Cmd_StopOnZero = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_bus.Cmd_Ready), 1);
        check("rst_request",   32'(cnt_request), 0);
        check("rst_set",       32'(cnt_set), 0);
        check("rst_dec",       32'(cnt_dec), 0);
        check("rst_in",        32'(cnt_in), 0);
        check("rst_done",      32'(done), 0);
        check("rst_flags",     {30'd0, zero_stop, timed_out}, 0);
        check("rst_remaining", 32'(remaining), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Preset 7, then INC 3: 7 -> 8 -> 9 -> 0
        run_cmd("set7", OP_SET, 8'd0, 4'd7, 1'b0, 8'd0);
        check("set7_value", 32'(value), 7);
        r0 = req_total; d0 = done_total; k0 = dec_req_total;
        run_cmd("inc3", OP_INC, 8'd3, 4'd0, 1'b0, 8'd0);
        check("inc3_requests", 32'(req_total - r0), 3);
        check("inc3_dec_reqs", 32'(dec_req_total - k0), 0);
        check("inc3_dones",    32'(done_total - d0), 1);
        check("inc3_zerostop", 32'(zs_seen), 0);
        check("inc3_value",    32'(value), 0);

        // Preset 2, DEC 5 with stop-on-zero: stops after 2 steps
        run_cmd("set2", OP_SET, 8'd0, 4'd2, 1'b0, 8'd0);
        r0 = req_total; k0 = dec_req_total;
        run_cmd("dec5", OP_DEC, 8'd5, 4'd0, 1'b1, 8'd3);
        check("dec5_requests", 32'(req_total - r0), 2);
        check("dec5_dec_reqs", 32'(dec_req_total - k0), 2);
        check("dec5_zerostop", 32'(zs_seen), 1);
        check("dec5_value",    32'(value), 0);

        // SET 9 then CLEAR
        r0 = req_total; s0 = set_total;
        run_cmd("set9", OP_SET, 8'd4, 4'd9, 1'b1, 8'd0);
        check("set9_set_cycles", 32'(set_total - s0), 2);
        check("set9_cnt_in",     32'(set_in_last), 9);
        check("set9_requests",   32'(req_total - r0), 0);
        check("set9_zerostop",   32'(zs_seen), 0);
        check("set9_value",      32'(value), 9);
        s0 = set_total;
        run_cmd("clear", OP_CLR, 8'd0, 4'd5, 1'b0, 8'd0);
        check("clear_set_cycles", 32'(set_total - s0), 2);
        check("clear_cnt_in",     32'(set_in_last), 0);
        check("clear_value",      32'(value), 0);

        // INC 0: no counter activity, Done the cycle after accept
        r0 = req_total; s0 = set_total;
        run_cmd("inc0", OP_INC, 8'd0, 4'd0, 1'b0, 8'd0);
        check("inc0_latency",  32'(done_lat), 0);
        check("inc0_requests", 32'(req_total - r0), 0);
        check("inc0_sets",     32'(set_total - s0), 0);

        // Watchdog: counter never reports ready after the first step
        stall = 1'b1;
        r0 = req_total; w0 = wait_total;
        run_cmd("wdog", OP_INC, 8'd4, 4'd0, 1'b0, 8'd3);
        check("wdog_timedout",    32'(to_seen), 1);
        check("wdog_requests",    32'(req_total - r0), 1);
        check("wdog_wait_cycles", 32'(wait_total - w0), 10);
        stall = 1'b0;
        repeat (8) @(negedge clk);
        check("wdog_held", 32'(timed_out), 1);
        exp_q.push_back(8'd0);
        send_cmd(OP_INC, 8'd0, 4'd0, 1'b0);
        check("wdog_cleared", 32'(timed_out), 0);
        finish_cmd("after_wdog");

        // Abort pulsed in GUARD of step 2 of INC 6
        r0 = req_total;
        exp_q.push_back(8'd4);
        send_cmd(OP_INC, 8'd6, 4'd0, 1'b0);
        n = 0;
        while (!((req_total - r0) == 2 && dbg_state == ST_GUARD) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("abort_guard_timeout", 32'(n), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        finish_cmd("abort");
        check("abort_requests", 32'(req_total - r0), 2);

        check("no_req_set_overlap", 32'(overlap_total), 0);
        check("min_req_spacing",    32'(min_gap >= 3), 1);

        // Reset asserted mid-WAIT of a DEC command
        send_cmd(OP_DEC, 8'd3, 4'd0, 1'b0);
        n = 0;
        while (dbg_state != ST_WAIT && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_dec", 32'(cnt_dec), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_state",     32'(dbg_state), 32'(ST_IDLE));
        check("midrst_cmd_ready", 32'(cmd_bus.Cmd_Ready), 1);
        check("midrst_dec",       32'(cnt_dec), 0);
        check("midrst_remaining", 32'(remaining), 0);
        check("midrst_done",      32'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        r0 = req_total;
        run_cmd("post_rst_inc1", OP_INC, 8'd1, 4'd0, 1'b0, 8'd0);
        check("post_rst_requests", 32'(req_total - r0), 1);
        check("post_rst_flags",    {30'd0, zs_seen, to_seen}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
